// File: rtl/sonic_dma_pkg.sv
// Shared types and constants for the DMA descriptor fetch path.
//   DESC_BYTES     size of one descriptor in the RC-side table
//   EPLAST_OFS     byte offset of the EPLast status word from the table base
//   desc_t         one descriptor, {DW3,DW2,DW1,DW0}
//   fifo_entry_t   descriptor plus its table index, as held in the FIFO
//   fetch_state_t  descriptor fetch FSM states
package sonic_dma_pkg;

  localparam int unsigned DESC_BYTES = 16;
  localparam int unsigned EPLAST_OFS = 12;

  typedef struct packed {
    logic [31:0] dw3;
    logic [31:0] dw2;
    logic [31:0] dw1;
    logic [31:0] dw0;
  } desc_t;

  typedef struct packed {
    logic [15:0] idx;
    desc_t       desc;
  } fifo_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CPL0,
    ST_CPL1,
    ST_ERR
  } fetch_state_t;

endpackage

// File: rtl/sonic_dma_desc_fifo.sv
// Synchronous first-word fall-through FIFO with an occupancy count.
//   clk_in     clock
//   rstn       synchronous active-low reset
//   flush      synchronous clear (same effect as reset)
//   push       write push_data (ignored when full)
//   push_data  entry to write
//   pop        drop the head entry (ignored when empty)
//   pop_data   head entry, all zeros while empty
//   empty      no entries held
//   count      number of entries held, 0..DEPTH
module sonic_dma_desc_fifo #(
  parameter int unsigned WIDTH = 144,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rstn || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sonic_dma_desc_fetch.sv
// Descriptor-table reader: walks the RC-side descriptor table up to the index
// the host last published, queues descriptors for the DMA engine and writes
// EPLast status back to the RC.
//   clk_in, rstn              clock, synchronous active-low reset
//   init                      soft init; high = flush and idle
//   dt_size, dt_base_rc       table size minus 1, table base address
//   dt_3dw_rcadd              base fits in 32 bits, use 3DW header
//   dt_rc_last                last descriptor index published by the host
//   dt_eplast_ena             enable EPLast writeback
//   rd_req_*                  4-DW memory-read request (valid/ready)
//   cpl_valid/data/err        64-bit completion beats, two per descriptor
//   desc_valid/ready/data/idx FWFT descriptor output
//   desc_done, desc_done_idx  consumer reports a finished descriptor
//   eplast_valid/ready/addr/data  EPLast memory-write request
//   fetch_err                 sticky completion error
module sonic_dma_desc_fetch
  import sonic_dma_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned HDR_BYTES  = 16
) (
  input  logic          clk_in,
  input  logic          rstn,
  input  logic          init,
  input  logic [15:0]   dt_size,
  input  logic [63:0]   dt_base_rc,
  input  logic          dt_3dw_rcadd,
  input  logic [15:0]   dt_rc_last,
  input  logic          dt_eplast_ena,
  output logic          rd_req_valid,
  input  logic          rd_req_ready,
  output logic [63:0]   rd_req_addr,
  output logic          rd_req_3dw,
  input  logic          cpl_valid,
  input  logic [63:0]   cpl_data,
  input  logic          cpl_err,
  output logic          desc_valid,
  input  logic          desc_ready,
  output logic [127:0]  desc_data,
  output logic [15:0]   desc_idx,
  input  logic          desc_done,
  input  logic [15:0]   desc_done_idx,
  output logic          eplast_valid,
  input  logic          eplast_ready,
  output logic [63:0]   eplast_addr,
  output logic [31:0]   eplast_data,
  output logic          fetch_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t state_q, state_d;
  logic [15:0]  fetch_idx_q, fetch_idx_d;
  logic         done_q, done_d;
  logic [15:0]  last_q, last_d;
  logic [63:0]  beat0_q, beat0_d;
  logic         rd_req_valid_q, rd_req_valid_d;
  logic [63:0]  rd_req_addr_q, rd_req_addr_d;
  logic         rd_req_3dw_q, rd_req_3dw_d;
  logic         fetch_err_q, fetch_err_d;
  logic         ep_pend_q, ep_pend_d;
  logic [63:0]  ep_addr_q, ep_addr_d;
  logic [31:0]  ep_data_q, ep_data_d;

  logic          push;
  fifo_entry_t   push_entry, pop_entry;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign push_entry = {fetch_idx_q, cpl_data, beat0_q};

  always_comb begin
    state_d        = state_q;
    fetch_idx_d    = fetch_idx_q;
    done_d         = done_q;
    last_d         = dt_rc_last;
    beat0_d        = beat0_q;
    rd_req_valid_d = rd_req_valid_q;
    rd_req_addr_d  = rd_req_addr_q;
    rd_req_3dw_d   = rd_req_3dw_q;
    fetch_err_d    = fetch_err_q;
    push           = 1'b0;

    // A newly published rc_last re-arms fetching from the current index.
    if (dt_rc_last != last_q) begin
      done_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Only one read is ever in flight, so a free slot now is still free
        // when its completion lands.
        if (!done_d && (fifo_count < CW'(FIFO_DEPTH))) begin
          state_d        = ST_REQ;
          rd_req_valid_d = 1'b1;
          rd_req_addr_d  = dt_base_rc + 64'(HDR_BYTES)
                         + 64'(fetch_idx_q) * 64'(DESC_BYTES);
          rd_req_3dw_d   = dt_3dw_rcadd;
        end
      end
      ST_REQ: begin
        if (rd_req_ready) begin
          rd_req_valid_d = 1'b0;
          state_d        = ST_CPL0;
        end
      end
      ST_CPL0: begin
        if (cpl_valid) begin
          if (cpl_err) begin
            fetch_err_d = 1'b1;
            state_d     = ST_ERR;
          end else begin
            beat0_d = cpl_data;
            state_d = ST_CPL1;
          end
        end
      end
      ST_CPL1: begin
        if (cpl_valid) begin
          if (cpl_err) begin
            fetch_err_d = 1'b1;
            state_d     = ST_ERR;
          end else begin
            push    = 1'b1;
            state_d = ST_IDLE;
            if (fetch_idx_q == dt_rc_last) begin
              done_d = 1'b1;
            end
            fetch_idx_d = (fetch_idx_q == dt_size) ? '0 : fetch_idx_q + 16'd1;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // EPLast: a new desc_done always wins over an accept in the same cycle, and
  // back-to-back completions coalesce into a single write of the newest index.
  always_comb begin
    ep_pend_d = ep_pend_q;
    ep_addr_d = ep_addr_q;
    ep_data_d = ep_data_q;
    if (ep_pend_q && eplast_ready) begin
      ep_pend_d = 1'b0;
    end
    if (desc_done && dt_eplast_ena) begin
      ep_pend_d = 1'b1;
      ep_data_d = {16'h0, desc_done_idx};
      ep_addr_d = dt_base_rc + 64'(EPLAST_OFS);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rstn || init) begin
      state_q        <= ST_IDLE;
      fetch_idx_q    <= '0;
      done_q         <= 1'b0;
      last_q         <= '0;
      beat0_q        <= '0;
      rd_req_valid_q <= 1'b0;
      rd_req_addr_q  <= '0;
      rd_req_3dw_q   <= 1'b0;
      fetch_err_q    <= 1'b0;
      ep_pend_q      <= 1'b0;
      ep_addr_q      <= '0;
      ep_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      fetch_idx_q    <= fetch_idx_d;
      done_q         <= done_d;
      last_q         <= last_d;
      beat0_q        <= beat0_d;
      rd_req_valid_q <= rd_req_valid_d;
      rd_req_addr_q  <= rd_req_addr_d;
      rd_req_3dw_q   <= rd_req_3dw_d;
      fetch_err_q    <= fetch_err_d;
      ep_pend_q      <= ep_pend_d;
      ep_addr_q      <= ep_addr_d;
      ep_data_q      <= ep_data_d;
    end
  end

  sonic_dma_desc_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rstn      (rstn),
    .flush     (init),
    .push      (push),
    .push_data (push_entry),
    .pop       (desc_ready),
    .pop_data  (pop_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rd_req_valid = rd_req_valid_q;
  assign rd_req_addr  = rd_req_addr_q;
  assign rd_req_3dw   = rd_req_3dw_q;
  assign fetch_err    = fetch_err_q;
  assign desc_valid   = !fifo_empty;
  assign desc_data    = pop_entry.desc;
  assign desc_idx     = pop_entry.idx;
  assign eplast_valid = ep_pend_q;
  assign eplast_addr  = ep_addr_q;
  assign eplast_data  = ep_data_q;

endmodule

// File: tb/tb_sonic_dma_desc_fetch.sv
`timescale 1ns/1ps
module tb_sonic_dma_desc_fetch;

  logic          clk_in = 1'b0;
  logic          rstn, init;
  logic [15:0]   dt_size, dt_rc_last;
  logic [63:0]   dt_base_rc;
  logic          dt_3dw_rcadd, dt_eplast_ena;
  logic          rd_req_valid, rd_req_ready, rd_req_3dw;
  logic [63:0]   rd_req_addr;
  logic          cpl_valid, cpl_err;
  logic [63:0]   cpl_data;
  logic          desc_valid, desc_ready;
  logic [127:0]  desc_data;
  logic [15:0]   desc_idx;
  logic          desc_done;
  logic [15:0]   desc_done_idx;
  logic          eplast_valid, eplast_ready;
  logic [63:0]   eplast_addr;
  logic [31:0]   eplast_data;
  logic          fetch_err;

  always #5 clk_in = ~clk_in;

  sonic_dma_desc_fetch #(.FIFO_DEPTH(8), .HDR_BYTES(16)) dut (
    .clk_in(clk_in), .rstn(rstn), .init(init),
    .dt_size(dt_size), .dt_base_rc(dt_base_rc), .dt_3dw_rcadd(dt_3dw_rcadd),
    .dt_rc_last(dt_rc_last), .dt_eplast_ena(dt_eplast_ena),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_3dw(rd_req_3dw),
    .cpl_valid(cpl_valid), .cpl_data(cpl_data), .cpl_err(cpl_err),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_data(desc_data), .desc_idx(desc_idx),
    .desc_done(desc_done), .desc_done_idx(desc_done_idx),
    .eplast_valid(eplast_valid), .eplast_ready(eplast_ready),
    .eplast_addr(eplast_addr), .eplast_data(eplast_data),
    .fetch_err(fetch_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Host memory contents: every descriptor's payload is a function of its address.
  function automatic logic [63:0] beat(input logic [63:0] a, input int k);
    if (k == 0) return {a[31:0] ^ 32'h5A5A_0000, a[31:0]};
    return {~a[31:0], a[31:0] + 32'h1};
  endfunction

  function automatic logic [63:0] m_addr(input logic [15:0] idx);
    return dt_base_rc + 64'd16 + {48'h0, idx} * 64'd16;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { logic [15:0] idx; logic [127:0] data; } exp_t;
  exp_t          exp_q[$];
  exp_t          e;
  logic [63:0]   rd_log[$];
  logic [15:0]   pop_log[$];
  logic [15:0]   m_next = '0;
  logic [15:0]   m_last = '0;
  bit            m_done = 0, m_err = 0;
  bit            ep_pend = 0;
  logic [31:0]   ep_data = '0;
  logic [63:0]   ep_addr = '0;
  int            n_reads = 0, n_ep = 0;
  logic [31:0]   last_ep = '0;
  bit            started = 0;
  bit            hs_ok;

  always @(negedge clk_in) begin
    if (started) begin
      hs_ok = rstn && !init;
      if (rd_req_valid) begin
        checks++;
        if (m_done || m_err) begin
          errors++;
          $display("FAIL rd_unexpected: got request addr %h required no request", rd_req_addr);
        end else begin
          chk("rd_addr", rd_req_addr, m_addr(m_next));
          chk("rd_3dw", rd_req_3dw, dt_3dw_rcadd);
          if (rd_req_ready && hs_ok) begin
            e.idx  = m_next;
            e.data = {beat(m_addr(m_next), 1), beat(m_addr(m_next), 0)};
            exp_q.push_back(e);
            rd_log.push_back(rd_req_addr);
            n_reads++;
            if (m_next == dt_rc_last) m_done = 1;
            m_next = (m_next == dt_size) ? 16'd0 : m_next + 16'd1;
          end
        end
      end
      if (desc_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL desc_unexpected: got idx %0d required no descriptor", desc_idx);
        end else begin
          chk("desc_idx", desc_idx, exp_q[0].idx);
          chk("desc_data", desc_data, exp_q[0].data);
          if (desc_ready && hs_ok) begin
            pop_log.push_back(desc_idx);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("desc_data_idle", desc_data, '0);
      end
      chk("fetch_err", fetch_err, m_err);
      chk("ep_valid", eplast_valid, ep_pend);
      if (ep_pend) begin
        chk("ep_data", eplast_data, ep_data);
        chk("ep_addr", eplast_addr, ep_addr);
      end
      if (eplast_valid && eplast_ready && hs_ok) begin
        n_ep++;
        last_ep = eplast_data;
      end
      // model update for the coming edge
      if (cpl_valid && cpl_err && hs_ok && !m_err) begin
        m_err = 1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
      end
      if (ep_pend && eplast_ready) ep_pend = 0;
      if (desc_done && dt_eplast_ena) begin
        ep_pend = 1;
        ep_data = {16'h0, desc_done_idx};
        ep_addr = dt_base_rc + 64'd12;
      end
      if (dt_rc_last != m_last) begin
        m_done = 0;
        m_last = dt_rc_last;
      end
      if (!hs_ok) begin
        m_next = '0; m_done = 0; m_err = 0; exp_q.delete();
        ep_pend = 0; ep_data = '0; ep_addr = '0; m_last = dt_rc_last;
      end
    end
  end

  // ---------------- completer (host memory) ----------------
  bit          err_arm = 0;
  logic [63:0] err_addr = '0;
  bit          lat_chk = 0;
  logic [63:0] ra;

  initial begin
    cpl_valid = 0; cpl_data = '0; cpl_err = 0;
    forever begin
      @(negedge clk_in);
      if (started && rstn && !init && rd_req_valid && rd_req_ready) begin
        ra = rd_req_addr;
        @(posedge clk_in);
        @(posedge clk_in); #1;
        cpl_valid = 1; cpl_data = beat(ra, 0); cpl_err = err_arm && (ra == err_addr);
        @(posedge clk_in); #1;
        if (cpl_err) begin
          cpl_valid = 0; cpl_err = 0;
        end else begin
          cpl_data = beat(ra, 1);
          @(posedge clk_in); #1;
          cpl_valid = 0;
          if (lat_chk) begin
            @(negedge clk_in);
            chk("latency_desc_valid", desc_valid, 1'b1);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  int base0, base_ep, k;

  initial begin
    rstn = 0; init = 0; dt_size = 16'd3; dt_base_rc = 64'h0000_0000_1000_0000;
    dt_3dw_rcadd = 1; dt_rc_last = 16'd1; dt_eplast_ena = 0;
    rd_req_ready = 1; desc_ready = 1; desc_done = 0; desc_done_idx = '0; eplast_ready = 0;
    cyc(2);
    started = 1;
    // reset state
    chk("rst_rd_valid", rd_req_valid, 1'b0);
    chk("rst_rd_addr", rd_req_addr, 64'h0);
    chk("rst_desc_valid", desc_valid, 1'b0);
    chk("rst_desc_data", desc_data, 128'h0);
    chk("rst_ep_valid", eplast_valid, 1'b0);
    chk("rst_fetch_err", fetch_err, 1'b0);

    // two reads up to rc_last=1
    lat_chk = 1;
    rstn = 1;
    cyc(40);
    chk("s1_reads", n_reads, 2);
    chk("s1_addr0", rd_log[0], 64'h1000_0010);
    chk("s1_addr1", rd_log[1], 64'h1000_0020);
    chk("s1_idx0", pop_log[0], 16'd0);
    chk("s1_idx1", pop_log[1], 16'd1);
    chk("s1_idle", rd_req_valid, 1'b0);

    // rc_last 3 then 0: idx 2,3 then wrap to 0
    dt_rc_last = 16'd3;
    cyc(40);
    dt_rc_last = 16'd0;
    cyc(30);
    chk("s2_reads", n_reads, 5);
    chk("s2_addr2", rd_log[2], 64'h1000_0030);
    chk("s2_addr3", rd_log[3], 64'h1000_0040);
    chk("s2_addr_wrap", rd_log[4], 64'h1000_0010);
    chk("s2_idx_wrap", pop_log[4], 16'd0);
    lat_chk = 0;

    // flow control against a stalled consumer
    init = 1; desc_ready = 0; dt_size = 16'd15; dt_rc_last = 16'd3;
    cyc(2);
    init = 0;
    base0 = n_reads;
    cyc(60);
    chk("s3_reads_4", n_reads - base0, 4);
    dt_rc_last = 16'd15;
    cyc(80);
    chk("s3_reads_full", n_reads - base0, 8);
    chk("s3_full_valid", desc_valid, 1'b1);
    chk("s3_full_noreq", rd_req_valid, 1'b0);
    desc_ready = 1;
    cyc(1);
    desc_ready = 0;
    cyc(40);
    chk("s3_one_more", n_reads - base0, 9);
    desc_ready = 1;
    cyc(100);
    chk("s3_drained_reads", n_reads - base0, 16);
    chk("s3_idle", rd_req_valid, 1'b0);

    // completion error on beat0 of idx 2
    init = 1; desc_ready = 0; dt_size = 16'd3; dt_rc_last = 16'd3;
    err_arm = 1; err_addr = 64'h1000_0030;
    cyc(2);
    init = 0;
    base0 = n_reads;
    cyc(40);
    chk("s4_fetch_err", fetch_err, 1'b1);
    chk("s4_reads", n_reads - base0, 3);
    chk("s4_noreq", rd_req_valid, 1'b0);
    chk("s4_queued", desc_valid, 1'b1);
    desc_ready = 1;
    cyc(10);
    chk("s4_drained", desc_valid, 1'b0);
    chk("s4_still_stopped", n_reads - base0, 3);
    err_arm = 0;
    init = 1;
    cyc(1);
    chk("s4_err_cleared", fetch_err, 1'b0);
    init = 0;
    k = 0;
    while (!rd_req_valid && k < 20) begin
      cyc(1);
      k++;
    end
    chk("s4_refetch_valid", rd_req_valid, 1'b1);
    chk("s4_refetch_addr", rd_req_addr, 64'h1000_0010);
    cyc(40);

    // EPLast coalescing
    dt_eplast_ena = 1; eplast_ready = 0;
    desc_done = 1; desc_done_idx = 16'd5;
    cyc(1);
    desc_done_idx = 16'd6;
    cyc(1);
    desc_done = 0;
    cyc(2);
    chk("s5_ep_valid", eplast_valid, 1'b1);
    chk("s5_ep_data", eplast_data, 32'h6);
    chk("s5_ep_addr", eplast_addr, 64'h1000_000C);
    base_ep = n_ep;
    eplast_ready = 1;
    cyc(1);
    eplast_ready = 0;
    cyc(2);
    chk("s5_single_write", n_ep - base_ep, 1);
    chk("s5_written_data", last_ep, 32'h6);
    chk("s5_ep_cleared", eplast_valid, 1'b0);
    // done in the accept cycle keeps the request pending with the new index
    desc_done = 1; desc_done_idx = 16'd3;
    cyc(1);
    desc_done_idx = 16'd7; eplast_ready = 1;
    cyc(1);
    desc_done = 0; eplast_ready = 0;
    cyc(1);
    chk("s5_repend_valid", eplast_valid, 1'b1);
    chk("s5_repend_data", eplast_data, 32'h7);
    chk("s5_first_write", last_ep, 32'h3);
    eplast_ready = 1;
    cyc(2);
    eplast_ready = 0;
    chk("s5_writes", n_ep - base_ep, 3);
    chk("s5_last_write", last_ep, 32'h7);
    // ignored while disabled
    dt_eplast_ena = 0;
    desc_done = 1; desc_done_idx = 16'd9;
    cyc(1);
    desc_done = 0;
    cyc(2);
    chk("s5_disabled_valid", eplast_valid, 1'b0);
    chk("s5_disabled_data", eplast_data, 32'h7);

    // init during a stalled request, then a stale completion
    rd_req_ready = 0;
    init = 1;
    cyc(1);
    init = 0;
    k = 0;
    while (!rd_req_valid && k < 20) begin
      cyc(1);
      k++;
    end
    chk("s6_req_pending", rd_req_valid, 1'b1);
    init = 1;
    cyc(1);
    chk("s6_req_dropped", rd_req_valid, 1'b0);
    init = 0;
    cpl_valid = 1; cpl_data = 64'hDEAD_BEEF_0000_0001;
    cyc(1);
    cpl_data = 64'hDEAD_BEEF_0000_0002;
    cyc(1);
    cpl_valid = 0; cpl_data = '0;
    cyc(3);
    chk("s6_stale_ignored", desc_valid, 1'b0);
    rd_req_ready = 1;
    base0 = n_reads;
    cyc(40);
    chk("s6_resume_reads", n_reads - base0, 4);
    chk("s6_resume_drained", desc_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
